// File: rtl/game_flow_controller.sv
// Game sequencer for the pipe-dodging game: state, bird physics, collisions, score.
// Optional best-score tracking is built when BEST_SCORE_EN is defined.
module game_flow_controller #(
   parameter int PHYS_DIVIDER    = 833333,
   parameter int SCREEN_HEIGHT   = 480,
   parameter int BIRD_X          = 160,
   parameter int BIRD_SIZE       = 24,
   parameter int START_Y         = 228,
   parameter int GRAVITY         = 1,
   parameter int FLAP_VEL        = 8,
   parameter int MAX_FALL        = 10,
   parameter int PIPE_WIDTH      = 52,
   parameter int PIPE_GAP        = 100,
   parameter int OVER_HOLD_TICKS = 30
) (
   input  logic               iClock,
   input  logic               iReset,
   input  logic               iFlap,
   input  logic signed [31:0] iPipe1X,
   input  logic signed [31:0] iPipe2X,
   input  logic signed [31:0] iPipe3X,
   input  logic signed [31:0] iPipe1Y,
   input  logic signed [31:0] iPipe2Y,
   input  logic signed [31:0] iPipe3Y,
   output logic [1:0]         oState,
   output logic signed [31:0] oBirdY,
   output logic [15:0]        oScore,
   output logic [15:0]        oBestScore
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2,
      BAD  = 2'd3
   } state_t;

   localparam int TW = (PHYS_DIVIDER > 1) ? $clog2(PHYS_DIVIDER) : 1;
   localparam int HW = $clog2(OVER_HOLD_TICKS + 1);
   localparam logic [16:0] SCORE_MAX = 17'd9999;
   localparam logic [HW-1:0] HOLD_MAX = HW'(OVER_HOLD_TICKS);
   localparam logic signed [15:0] V_FLAP = 16'(-FLAP_VEL);
   localparam logic signed [15:0] V_MAX = 16'(MAX_FALL);
   localparam logic signed [15:0] V_GRAV = 16'(GRAVITY);

   state_t               state;
   logic signed [15:0]   vel;
   logic [TW-1:0]        tick_cnt;
   logic [HW-1:0]        hold;
   logic [2:0]           passed;
   logic                 flap_q;

   logic                 flap_ev;
   logic                 tick;
   logic signed [31:0]   px [3];
   logic signed [31:0]   py [3];
   logic signed [31:0]   bird_bot;
   logic                 hit;
   logic [2:0]           pass_set;
   logic [2:0]           pass_clr;
   logic [1:0]           pass_cnt;
   logic [16:0]          score_sum;
   logic [15:0]          score_nxt;
   logic signed [15:0]   vel_inc;
   logic signed [15:0]   vel_fall;

   assign oState  = state;
   assign flap_ev = iFlap & ~flap_q;
   assign tick    = (tick_cnt == TW'(PHYS_DIVIDER - 1));

   assign px[0] = iPipe1X;
   assign px[1] = iPipe2X;
   assign px[2] = iPipe3X;
   assign py[0] = iPipe1Y;
   assign py[1] = iPipe2Y;
   assign py[2] = iPipe3Y;

   assign bird_bot = oBirdY + BIRD_SIZE;

   always_comb begin
      hit      = (oBirdY < 0) || (bird_bot > SCREEN_HEIGHT);
      pass_set = '0;
      pass_clr = '0;
      pass_cnt = '0;
      for (int i = 0; i < 3; i++) begin
         if (py[i] != -32'sd1) begin
            if ((px[i] < BIRD_X + BIRD_SIZE) &&
                (px[i] + PIPE_WIDTH > BIRD_X) &&
                ((oBirdY < py[i]) ||
                 (bird_bot > py[i] + PIPE_GAP)))
               hit = 1'b1;
            pass_set[i] = !passed[i] &&
                          (px[i] + PIPE_WIDTH < BIRD_X);
         end
         pass_clr[i] = (px[i] >= BIRD_X);
         pass_cnt    = pass_cnt + 2'(pass_set[i]);
      end
   end

   assign score_sum = 17'(oScore) + 17'(pass_cnt);
   assign score_nxt = (score_sum > SCORE_MAX) ? SCORE_MAX[15:0]
                                              : score_sum[15:0];

   assign vel_inc  = vel + V_GRAV;
   assign vel_fall = (vel_inc > V_MAX) ? V_MAX : vel_inc;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state    <= IDLE;
         oBirdY   <= 32'(START_Y);
         vel      <= '0;
         oScore   <= '0;
         tick_cnt <= '0;
         hold     <= '0;
         passed   <= '0;
         flap_q   <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         flap_q   <= iFlap;
         unique case (state)
            IDLE: begin
               oBirdY <= 32'(START_Y);
               if (flap_ev) begin
                  state  <= PLAY;
                  oScore <= '0;
                  vel    <= V_FLAP;
                  passed <= '0;
               end
            end
            PLAY: begin
               oScore <= score_nxt;
               passed <= (passed | pass_set) & ~pass_clr;
               // A collision freezes the bird where it hit
               if (hit) begin
                  state <= OVER;
                  hold  <= '0;
               end else if (tick) begin
                  oBirdY <= oBirdY + 32'(vel);
                  vel    <= flap_ev ? V_FLAP : vel_fall;
               end else if (flap_ev) begin
                  vel <= V_FLAP;
               end
            end
            OVER: begin
               if (tick && hold != HOLD_MAX)
                  hold <= hold + 1'b1;
               if (flap_ev && hold == HOLD_MAX) begin
                  state  <= IDLE;
                  oBirdY <= 32'(START_Y);
                  vel    <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BEST_SCORE_EN
   logic [15:0] best;

   always_ff @(posedge iClock) begin
      if (iReset)
         best <= '0;
      else if (state == PLAY && hit && score_nxt > best)
         best <= score_nxt;
   end

   assign oBestScore = best;
`else
   assign oBestScore = '0;
`endif

endmodule
